piso_shift_n: RTL and testbench

//  Parametrised parallel-in/serial-out shift register; next generation of the 74165-style PISO.

---
 rtl/piso_shift_n.sv | 119 +++++++++++
 tb/tb_piso_shift_n.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_n.sv
// Parametrised PISO shift register with frame counter, load handshake and done pulse.
// Optional even-parity tail bit appended to each frame when PISO_PARITY_EN is defined.
module piso_shift_n #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             cp,
  input  logic             mr,
  input  logic [WIDTH-1:0] d,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             n_ce,
  input  logic             ds,
  output logic             q,
  output logic             n_q,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned REG_W = FRAME_LEN;
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [REG_W-1:0]   r_sreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;

  logic [REG_W-1:0]   w_load_word;
  logic [REG_W-1:0]   w_shift_word;
  logic               w_shift_en;
  logic               w_cnt_last;
  logic               w_ld_ready;
  logic               w_load;
  logic               w_last;

  assign w_shift_en = ~n_ce;
  assign w_cnt_last = (r_cnt == CNT_W'(1));
  assign w_ld_ready = (r_state == S_IDLE) || (w_cnt_last && w_shift_en);
  assign w_load     = ld_valid && w_ld_ready;
  assign w_last     = (r_state == S_SHIFT) && w_shift_en && w_cnt_last;

  // The parity tail sits at the far end from the output so it leaves last.
`ifdef PISO_PARITY_EN
  logic w_par;
  assign w_par       = ^d;
  assign w_load_word = LSB_FIRST ? {w_par, d} : {d, w_par};
`else
  assign w_load_word = d;
`endif

  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_shift_word = {ds, r_sreg[REG_W-1:1]};
    end else begin : g_msb
      assign w_shift_word = {r_sreg[REG_W-2:0], ds};
    end
  endgenerate

  // State register
  always_ff @(posedge cp) begin
    if (mr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a back-to-back load on the final shift keeps the FSM in SHIFT
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_load) w_state_nxt = S_SHIFT;
               else if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load wins over shift; counting only while a frame is in flight
  always_ff @(posedge cp) begin
    if (mr) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_load) begin
        r_sreg <= w_load_word;
        r_cnt  <= CNT_W'(FRAME_LEN);
      end else if (w_shift_en) begin
        r_sreg <= w_shift_word;
        if (r_state == S_SHIFT) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Outputs
  always_comb begin
    busy     = (r_state == S_SHIFT);
    ld_ready = w_ld_ready;
    done     = r_done;
    q        = LSB_FIRST ? r_sreg[0] : r_sreg[REG_W-1];
    n_q      = ~q;
  end

endmodule

// File: tb/tb_piso_shift_n.sv
// Self-checking bench for piso_shift_n: MSB-first and LSB-first instances share stimulus
// and are compared against a bit-queue reference model of the frame stream.
module tb_piso_shift_n;
  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FL = W + 1;
`else
  localparam int unsigned FL = W;
`endif

  logic         cp = 1'b0;
  logic         mr = 1'b0;
  logic [W-1:0] d = '0;
  logic         ld_valid = 1'b0;
  logic         n_ce = 1'b1;
  logic         ds = 1'b0;
  logic         q_m, nq_m, busy_m, done_m, rdy_m;
  logic         q_l, nq_l, busy_l, done_l, rdy_l;

  int checks = 0;
  int errors = 0;

  // Reference model: queues hold register bits in output order (element 0 is on q)
  logic mm[$];
  logic ml[$];
  int   m_rem  = 0;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;

  always #5 cp = ~cp;

  piso_shift_n #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .cp(cp), .mr(mr), .d(d), .ld_valid(ld_valid), .ld_ready(rdy_m), .n_ce(n_ce),
    .ds(ds), .q(q_m), .n_q(nq_m), .busy(busy_m), .done(done_m)
  );

  piso_shift_n #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .cp(cp), .mr(mr), .d(d), .ld_valid(ld_valid), .ld_ready(rdy_l), .n_ce(n_ce),
    .ds(ds), .q(q_l), .n_q(nq_l), .busy(busy_l), .done(done_l)
  );

  function automatic logic [9:0] obs_vec();
    return {q_m, nq_m, q_l, nq_l, busy_m, done_m, rdy_m, busy_l, done_l, rdy_l};
  endfunction

  function automatic logic [9:0] exp_vec();
    logic er;
    er = !m_busy || (m_rem == 1 && !n_ce);
    return {mm[0], ~mm[0], ml[0], ~ml[0], m_busy, m_done, er, m_busy, m_done, er};
  endfunction

  task automatic model_reset();
    mm.delete(); ml.delete();
    for (int i = 0; i < FL; i++) begin mm.push_back(1'b0); ml.push_back(1'b0); end
    m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_load(input logic [W-1:0] dd);
    mm.delete(); ml.delete();
    for (int i = W - 1; i >= 0; i--) mm.push_back(dd[i]);
    for (int i = 0; i < W; i++) ml.push_back(dd[i]);
`ifdef PISO_PARITY_EN
    mm.push_back(^dd); ml.push_back(^dd);
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle past the edge
  task automatic tick(input logic v, input logic [W-1:0] dd, input logic nce,
                      input logic s, input logic r);
    bit rdy, ld, last;
    ld_valid = v; d = dd; n_ce = nce; ds = s; mr = r;
    @(posedge cp);
    if (r) begin
      model_reset();
    end else begin
      rdy  = !m_busy || (m_rem == 1 && !nce);
      ld   = v && rdy;
      last = m_busy && !nce && (m_rem == 1);
      if (ld) begin
        model_load(dd); m_rem = FL; m_busy = 1'b1;
      end else if (!nce) begin
        void'(mm.pop_front()); mm.push_back(s);
        void'(ml.pop_front()); ml.push_back(s);
        if (m_busy) begin
          m_rem--;
          if (m_rem == 0) m_busy = 1'b0;
        end
      end
      m_done = last;
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    tick(1'b1, '1, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({q_m, nq_m, busy_m, done_m, rdy_m} !== 5'b01001) begin
      errors++; $display("FAIL reset_msb: got %b expected 01001", {q_m, nq_m, busy_m, done_m, rdy_m});
    end
    checks++;
    if ({q_l, nq_l, busy_l, done_l, rdy_l} !== 5'b01001) begin
      errors++; $display("FAIL reset_lsb: got %b expected 01001", {q_l, nq_l, busy_l, done_l, rdy_l});
    end
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_hold: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_shift_order();
    logic [W-1:0] w;
    w = 8'h0F;
    tick(1'b1, w, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (q_m !== w[W-1-i] || q_l !== w[i] || busy_m !== 1'b1) begin
        errors++; $display("FAIL order_bit%0d: got q_m=%b q_l=%b busy=%b expected %b %b 1",
                           i, q_m, q_l, busy_m, w[W-1-i], w[i]);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL order_model%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    end
`ifdef PISO_PARITY_EN
    checks++;
    if (q_m !== ^w || q_l !== ^w || done_m !== 1'b0) begin
      errors++; $display("FAIL order_parity: got q_m=%b q_l=%b done=%b expected %b %b 0",
                         q_m, q_l, done_m, ^w, ^w);
    end
    tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
`endif
    checks++;
    if ({done_m, done_l, busy_m, q_m, q_l} !== 5'b11011) begin
      errors++; $display("FAIL order_end: got %b expected 11011", {done_m, done_l, busy_m, q_m, q_l});
    end
    tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (done_m !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL order_done_once: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    int ndone;
    w = 8'hA5; ndone = 0;
    tick(1'b1, w, 1'b0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
      ndone += int'(done_m);
      checks++;
      if (q_m !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_hold%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 2; i < W; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      ndone += int'(done_m);
      checks++;
      if (q_m !== w[W-1-i] || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_resume%0d: got q=%b vec=%b expected q=%b vec=%b",
                           i, q_m, obs_vec(), w[W-1-i], exp_vec());
      end
    end
    for (int i = 0; i < int'(FL - W) + 3; i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      ndone += int'(done_m);
    end
    checks++;
    if (ndone !== 1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL stall_done_count: got %0d busy=%b expected 1 busy=0", ndone, busy_m);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_bits[$];
    logic [W-1:0] w0, w1;
    int ndone;
    w0 = 8'hA5; w1 = 8'h5A; ndone = 0;
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w0[i]);
`ifdef PISO_PARITY_EN
    exp_bits.push_back(^w0);
`endif
    for (int i = W - 1; i >= 0; i--) exp_bits.push_back(w1[i]);
`ifdef PISO_PARITY_EN
    exp_bits.push_back(^w1);
`endif
    tick(1'b1, w0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 2 * int'(FL); j++) begin
      if (done_m) begin
        ndone++;
        checks++;
        if (j != int'(FL)) begin
          errors++; $display("FAIL b2b_done_pos: got done at bit %0d expected at bit %0d", j, FL);
        end
      end
      checks++;
      if (q_m !== exp_bits[j] || busy_m !== 1'b1 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL b2b_bit%0d: got q=%b busy=%b vec=%b expected q=%b busy=1 vec=%b",
                           j, q_m, busy_m, obs_vec(), exp_bits[j], exp_vec());
      end
      tick((j < int'(FL)) ? 1'b1 : 1'b0, (j == 0) ? w0 : w1, 1'b0, 1'b0, 1'b0);
    end
    ndone += int'(done_m);
    checks++;
    if (ndone !== 2 || busy_m !== 1'b0) begin
      errors++; $display("FAIL b2b_done_count: got %0d busy=%b expected 2 busy=0", ndone, busy_m);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic         pexp [2];
    words[0] = 8'hA5; pexp[0] = 1'b0;
    words[1] = 8'h07; pexp[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, words[k], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < W; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (q_m !== pexp[k] || q_l !== pexp[k] || done_m !== 1'b0 || busy_m !== 1'b1) begin
        errors++; $display("FAIL parity_bit%0d: got q_m=%b q_l=%b done=%b busy=%b expected %b %b 0 1",
                           k, q_m, q_l, done_m, busy_m, pexp[k], pexp[k]);
      end
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (done_m !== 1'b1 || busy_m !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL parity_done%0d: got %b expected %b", k, obs_vec(), exp_vec());
      end
    end
  endtask
`endif

  task automatic test_reset_midframe();
    int ndone;
    ndone = 0;
    tick(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({q_m, nq_m, busy_m, done_m, rdy_m, q_l, busy_l} !== 7'b0100100) begin
      errors++; $display("FAIL midframe_reset: got %b expected 0100100",
                         {q_m, nq_m, busy_m, done_m, rdy_m, q_l, busy_l});
    end
    for (int i = 0; i < int'(FL); i++) begin
      tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
      ndone += int'(done_m) + int'(done_l);
    end
    checks++;
    if (ndone !== 0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL midframe_no_done: got done_count=%0d vec=%b expected 0 vec=%b",
                         ndone, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic v, nce, s, r;
    logic [W-1:0] dd;
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 2) == 0);
      nce = ($urandom_range(0, 3) == 0);
      s   = 1'($urandom);
      r   = ($urandom_range(0, 59) == 0);
      dd  = W'($urandom);
      tick(v, dd, nce, s, r);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cyc%0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    @(posedge cp);
    #1;
    test_reset();
    test_shift_order();
    test_stall();
    test_back_to_back();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
